// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// FSM states, q-word bit positions and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int VALID_BIT = 31;
    localparam int OVF_BIT   = 9;
    localparam int ERR_BIT   = 8;
    localparam int FRAME_LEN = 11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so full and empty differ.
// A pop in the same cycle frees a slot for a push into a full queue.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_kbd_mmio.sv
// PS/2 device-to-host receiver with a scan-code FIFO on the MMIO read path.
// q carries valid/ovf/err flags plus the head byte; rd_en pops and clears flags.
module ps2_kbd_mmio
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        rd_en,
    output logic [31:0]                 q,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_lvl;
    logic [FW-1:0] filt_cnt;
    logic          filt_hit;
    logic          sample;

    ps2_state_e    state, state_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_ok, frame_bad;
    logic          ovf, err;

    logic [7:0]    head;
    logic          full, empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    assign filt_hit = (clk_s2 != filt_lvl) &&
                      (filt_cnt == FW'(FILTER_LEN - 1));
    assign sample   = filt_hit && filt_lvl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_lvl <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_hit) begin
            filt_lvl <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign timeout = (state != ST_IDLE) &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state;
        bit_d     = bit_idx;
        sh_d      = shreg;
        par_d     = par_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (sample) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_s2) begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                    end
                end
                ST_DATA: begin
                    sh_d  = {dat_s2, shreg[7:1]};
                    bit_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s2;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_s2 && (^shreg ^ par_q)) frame_ok = 1'b1;
                    else                           frame_bad = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_d;
            bit_idx <= bit_d;
            shreg   <= sh_d;
            par_q   <= par_d;
            if (sample || state == ST_IDLE) to_cnt <= '0;
            else                            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A same-cycle pop frees the slot, so a full FIFO only overflows without rd_en.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            if (frame_ok && full && !rd_en) ovf <= 1'b1;
            else if (rd_en)                 ovf <= 1'b0;
            if (frame_bad)  err <= 1'b1;
            else if (rd_en) err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (frame_ok),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        q            = '0;
        q[VALID_BIT] = ~empty;
        q[OVF_BIT]   = ovf;
        q[ERR_BIT]   = err;
        if (!empty) q[7:0] = head;
    end

endmodule

// File: doc/ps2_kbd_mmio.md
Name: ps2_kbd_mmio

Overview:
- PS/2 device-to-host receiver feeding the processor's memory-mapped I/O read path.
- Synchronises the external ps2_clk/ps2_data lines, deframes 11-bit PS/2 frames and checks parity.
- Buffers received scan-code bytes in a small FIFO, popped by the processor's load from the keyboard I/O address.
- Sits beside the switch-read mux in the wrapper; q is selected onto q_dmem when the keyboard address decodes.

Parameters:
- FIFO_DEPTH, 16, entries in the byte FIFO; power of 2, minimum 2.
- FILTER_LEN, 4, consecutive equal samples required before a ps2_clk level change is accepted.
- TIMEOUT_CYCLES, 50000, clock cycles without an accepted falling edge before a partial frame is aborted.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- rd_en  in  1  one-cycle pop strobe (processor load of the keyboard address).
- q  out  32  status/data word, combinational from FIFO head and flags.
- count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: q=0, count=0; FIFO empty; flags cleared; FSM in IDLE; synchroniser and filter registers preset to 1 (idle-high bus).
- Input conditioning:
  - Two-flop synchroniser on each line.
  - ps2_clk filter: the filtered level changes only after FILTER_LEN consecutive synced samples at the new level.
  - An accepted falling edge of the filtered clock is the sample event; ps2_data (synced) is sampled in that same cycle.
- FSM, one transition per sample event:
  - IDLE: bit=0 -> DATA with bit index 0; bit=1 is ignored and stays in IDLE.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: frame is valid when stop=1 and (XOR of 8 data bits ^ parity)=1 (odd parity).
    - Valid, FIFO not full: push the byte.
    - Valid, FIFO full: drop the byte and set ovf.
    - Invalid: drop the byte and set err.
    - Always return to IDLE.
- Timeout:
  - Cycle counter resets on every sample event; counts only while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE with no push and no flag change.
- q format:
  - q[31]=~empty; q[9]=ovf; q[8]=err; q[7:0]=head byte when not empty, else 0; all other bits 0.
- Pop:
  - rd_en on a posedge with the FIFO not empty advances the head.
  - rd_en always clears ovf and err in that cycle; a flag set in the same cycle wins.
  - rd_en while empty: no pointer change, flags still cleared.
- Simultaneous push and pop in one cycle:
  - Both take effect; count unchanged.
  - When full, the pop frees the slot, so the push succeeds and ovf is not set.
- Pointers: wrap modulo FIFO_DEPTH; count is the pointer difference with an extra MSB so the full state is distinct.
- Latency:
  - Byte visible on q the cycle after the posedge that samples the stop bit.
  - Raw-line edge to sample event: 2 + FILTER_LEN cycles.
- Reset mid-frame: partial frame discarded immediately (asynchronous); the next start bit begins a fresh frame.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - q bit-position constants: VALID_BIT=31, OVF_BIT=9, ERR_BIT=8.
  - Frame length constant 11.
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable for other I/O queues.
- Synchroniser, filter and FSM stay in ps2_kbd_mmio.

Test Plan:
- Valid frame: send 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> q=32'h8000001C, count=1; rd_en pulse -> q=0, count=0.
- Parity error: send 0x1C with parity 1 -> count=0, q=32'h00000100; rd_en pulse -> q=0.
- Overflow: 17 frames 0x01..0x11 with no reads -> count=16, q=32'h80000201; 16 pops return 0x01..0x10 in order, ovf clears on the first pop.
- Full plus simultaneous pop: FIFO full, rd_en asserted in the same cycle the 17th stop bit is sampled -> count stays 16, q[9]=0, new byte is the last entry.
- Timeout and glitch:
  - 5 bits then idle for TIMEOUT_CYCLES+10 -> FSM in IDLE, count=0; next frame 0xF0 -> q=32'h800000F0.
  - A 2-cycle low glitch on ps2_clk (FILTER_LEN=4) creates no sample event.
- Reset mid-frame: assert reset after 6 bits -> count=0, q=0; following frame 0x5A received correctly.
